sub_seq: RTL and testbench

Nibble-serial multi-word subtractor controller. Computes a − b − bin on operands of 4·NIB bits by stepping a single 4-bit borrow-ripple nibble subtractor across the operand, one nibble per clock, LSB first. Borrow is registered between steps. Sits between a requester using a start/busy/done handshake and the shared nibble datapath, trading latency for area.

---
 rtl/sub_seq_pkg.sv | 5 +
 rtl/sub_seq_if.sv | 24 ++
 rtl/sub_seq_nib_sub.sv | 21 ++
 rtl/sub_seq.sv | 81 ++++++++
 tb/tb_sub_seq.sv | 138 +++++++++++++
 5 files changed

// File: rtl/sub_seq_pkg.sv
// sub_seq_pkg: shared types and constants for the nibble-serial subtractor.
package sub_seq_pkg;
    localparam int NIB_W = 4;
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
endpackage

// File: rtl/sub_seq_if.sv
// sub_seq_if: start/busy/done request bus; zero/ovf present only with SUB_SEQ_FLAGS_EN.
interface sub_seq_if #(
    parameter int NIB = 4
);
    import sub_seq_pkg::*;
    localparam int W = NIB_W * NIB;
    logic start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic bin;
    logic busy;
    logic done;
    logic [W-1:0] d;
    logic bout;
`ifdef SUB_SEQ_FLAGS_EN
    logic zero;
    logic ovf;
    modport master (output start, a, b, bin, input busy, done, d, bout, zero, ovf);
    modport slave (input start, a, b, bin, output busy, done, d, bout, zero, ovf);
`else
    modport master (output start, a, b, bin, input busy, done, d, bout);
    modport slave (input start, a, b, bin, output busy, done, d, bout);
`endif
endinterface

// File: rtl/sub_seq_nib_sub.sv
// nib_sub: combinational 4-bit borrow-ripple subtractor.
module nib_sub
    import sub_seq_pkg::*;
(
    input  logic [NIB_W-1:0] a,
    input  logic [NIB_W-1:0] b,
    input  logic             bin,
    output logic [NIB_W-1:0] d,
    output logic             bout
);
    logic c;
    always_comb begin
        c = bin;
        d = '0;
        for (int i = 0; i < NIB_W; i++) begin
            d[i] = a[i] ^ b[i] ^ c;
            c = (c & ~(a[i] ^ b[i])) | (~a[i] & b[i]);
        end
        bout = c;
    end
endmodule

// File: rtl/sub_seq.sv
// sub_seq: computes a - b - bin one nibble per clock, LSB first, through a single nib_sub.
// Defining SUB_SEQ_FLAGS_EN adds registered zero and signed-overflow flags.
module sub_seq
    import sub_seq_pkg::*;
#(
    parameter int NIB = 4
) (
    input logic clk,
    input logic rst_n,
    sub_seq_if.slave bus
);
    localparam int W = NIB_W * NIB;
    localparam int IW = $clog2(NIB);
    localparam logic [IW-1:0] last_idx = IW'(NIB - 1);
    state_t state, nxt;
    logic [W-1:0] a_r, b_r, d_r, d_nxt;
    logic [IW-1:0] idx;
    logic [NIB_W-1:0] nd;
    logic brw, bout_r, nb, accept, last;
    assign accept = state == IDLE && bus.start;
    assign last = idx == last_idx;
    nib_sub u_nib (
        .a(a_r[idx*NIB_W +: NIB_W]),
        .b(b_r[idx*NIB_W +: NIB_W]),
        .bin(brw),
        .d(nd),
        .bout(nb)
    );
    always_comb begin
        d_nxt = d_r;
        d_nxt[idx*NIB_W +: NIB_W] = nd;
    end
    always_comb nxt = state == IDLE ? (bus.start ? RUN : IDLE) : state == RUN ? (last ? DONE : RUN) : IDLE;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= IDLE;
        else state <= nxt;
    // idx parks on the last nibble so it never wraps for power-of-two NIB
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_r <= '0;
            b_r <= '0;
            d_r <= '0;
            brw <= 1'b0;
            bout_r <= 1'b0;
            idx <= '0;
        end else if (accept) begin
            a_r <= bus.a;
            b_r <= bus.b;
            brw <= bus.bin;
            d_r <= '0;
            bout_r <= 1'b0;
            idx <= '0;
        end else if (state == RUN) begin
            d_r <= d_nxt;
            brw <= nb;
            if (last) bout_r <= nb;
            else idx <= idx + 1'b1;
        end
    end
    assign bus.busy = state != IDLE;
    assign bus.done = state == DONE;
    assign bus.d = d_r;
    assign bus.bout = bout_r;
`ifdef SUB_SEQ_FLAGS_EN
    logic zero_r, ovf_r;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            zero_r <= 1'b0;
            ovf_r <= 1'b0;
        end else if (accept) begin
            zero_r <= 1'b0;
            ovf_r <= 1'b0;
        end else if (state == RUN && last) begin
            zero_r <= d_nxt == '0;
            ovf_r <= (a_r[W-1] != b_r[W-1]) && (d_nxt[W-1] != a_r[W-1]);
        end
    end
    assign bus.zero = zero_r;
    assign bus.ovf = ovf_r;
`endif
endmodule

// File: tb/tb_sub_seq.sv
// tb_sub_seq: directed and randomized checks of sub_seq against an arithmetic reference.
module tb_sub_seq;
    import sub_seq_pkg::*;
    localparam int NIB = 4;
    localparam int W = NIB_W * NIB;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int tests = 0;
    int fails = 0;
    sub_seq_if #(.NIB(NIB)) bus();
    sub_seq #(.NIB(NIB)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [W-1:0] rnd();
        return W'({$urandom(), $urandom()});
    endfunction

    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin, input bit scramble, input bit full);
        logic [W:0] diff;
        logic [W-1:0] exp_d;
        logic exp_bout;
        int n, nb;
        diff = {1'b0, a} - {1'b0, b} - (W+1)'(bin);
        exp_d = diff[W-1:0];
        exp_bout = {1'b0, a} < {1'b0, b} + (W+1)'(bin);
        @(negedge clk);
        bus.a = a;
        bus.b = b;
        bus.bin = bin;
        bus.start = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
        if (scramble) begin
            bus.a = rnd();
            bus.b = rnd();
            bus.bin = 1'($urandom());
        end
        n = 0;
        nb = 0;
        do begin
            @(negedge clk);
            n++;
            nb += int'(bus.busy);
            if (full && n == 1) check("d_clr", bus.d, 0);
            if (scramble) begin
                bus.start = bus.done ? 1'b0 : 1'($urandom());
                bus.a = rnd();
            end
        end while (!bus.done && n < 4 * NIB + 8);
        bus.start = 1'b0;
        check("lat", n, NIB + 1);
        check("busy", nb, NIB + 1);
        check("d", bus.d, exp_d);
        check("bout", bus.bout, exp_bout);
`ifdef SUB_SEQ_FLAGS_EN
        check("zero", bus.zero, exp_d == '0);
        check("ovf", bus.ovf, (a[W-1] != b[W-1]) && (exp_d[W-1] != a[W-1]));
`endif
        @(negedge clk);
        check("idle", {bus.busy, bus.done}, 0);
        if (full) check("hold", {bus.d, bus.bout}, {exp_d, exp_bout});
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int t[$];
        int c;
        bus.start = 1'b0;
        bus.a = '0;
        bus.b = '0;
        bus.bin = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_ctl", {bus.busy, bus.done, bus.bout}, 0);
        check("rst_d", bus.d, 0);
`ifdef SUB_SEQ_FLAGS_EN
        check("rst_flags", {bus.zero, bus.ovf}, 0);
`endif
        rst_n = 1'b1;
        run_op(W'(16'h1234), W'(16'h0235), 1'b0, 1'b0, 1'b1);
        run_op(W'(0), W'(1), 1'b0, 1'b0, 1'b1);
        run_op(W'(16'h0010), W'(0), 1'b1, 1'b0, 1'b1);
        run_op(W'(16'h8000), W'(1), 1'b0, 1'b1, 1'b1);
        run_op(W'(16'h1234), W'(16'h1234), 1'b0, 1'b1, 1'b1);
        run_op('1, '1, 1'b1, 1'b1, 1'b1);
        run_op('0, '1, 1'b1, 1'b1, 1'b1);
        // start held high: one result every NIB+2 cycles
        @(negedge clk);
        bus.a = W'(5);
        bus.b = W'(3);
        bus.bin = 1'b0;
        bus.start = 1'b1;
        c = 0;
        while (t.size() < 4 && c < 8 * (NIB + 2)) begin
            @(negedge clk);
            if (bus.done) begin
                t.push_back(c);
                check("b2b_d", {bus.d, bus.bout}, {W'(2), 1'b0});
            end
            c++;
        end
        bus.start = 1'b0;
        check("b2b_cnt", t.size(), 4);
        for (int i = 1; i < t.size(); i++) check("b2b_gap", t[i] - t[i-1], NIB + 2);
        @(negedge clk);
        check("b2b_idle", bus.busy, 0);
        // asynchronous reset while nibble 2 is in flight
        @(negedge clk);
        bus.a = W'(16'hABCD);
        bus.b = W'(16'h1111);
        bus.start = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort_ctl", {bus.busy, bus.done, bus.bout}, 0);
        check("abort_d", bus.d, 0);
        @(negedge clk);
        rst_n = 1'b1;
        run_op(W'(16'h0005), W'(16'h0003), 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 3000; i++) run_op(rnd(), rnd(), 1'($urandom()), 1'($urandom()), 1'b0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
